// File: rtl/dtlb_stage_if.sv
// Pipeline-side bundle for the data TLB: TL-stage request/tlbwrite inputs and translated outputs.
// The master is the pipeline and the slave is dtlb_stage.
interface dtlb_stage_if;
  logic        kill_i;
  logic        stall_core_i;
  logic        tl_cache_enable_i;
  logic        tl_store_i;
  logic [31:0] tl_cache_addr_i;
  logic        tl_tlbwrite_i;
  logic        tl_idtlb_i;
  logic [31:0] tl_read_data_a_i;
  logic [31:0] tl_read_data_b_i;
  logic        sup_mode_i;

  logic        dtlb_valid_o;
  logic        dtlb_store_o;
  logic [31:0] dtlb_paddr_o;
  logic        dtlb_miss_o;
  logic [31:0] dtlb_fault_vaddr_o;
  logic [31:0] dtlb_hits_o;
  logic [31:0] dtlb_misses_o;

  modport master (
    output kill_i, stall_core_i, tl_cache_enable_i, tl_store_i, tl_cache_addr_i,
           tl_tlbwrite_i, tl_idtlb_i, tl_read_data_a_i, tl_read_data_b_i, sup_mode_i,
    input  dtlb_valid_o, dtlb_store_o, dtlb_paddr_o, dtlb_miss_o, dtlb_fault_vaddr_o,
           dtlb_hits_o, dtlb_misses_o
  );

  modport slave (
    input  kill_i, stall_core_i, tl_cache_enable_i, tl_store_i, tl_cache_addr_i,
           tl_tlbwrite_i, tl_idtlb_i, tl_read_data_a_i, tl_read_data_b_i, sup_mode_i,
    output dtlb_valid_o, dtlb_store_o, dtlb_paddr_o, dtlb_miss_o, dtlb_fault_vaddr_o,
           dtlb_hits_o, dtlb_misses_o
  );
endinterface

// File: rtl/dtlb_stage.sv
// dtlb_stage: fully-associative data TLB with FIFO replacement, 1-cycle registered lookup, and a sticky miss held until kill.
// stall_core_i freezes all state; defining DTLB_STATS_EN adds saturating hit/miss counters (otherwise they are tied to 0).
module dtlb_stage #(
  parameter int ENTRIES   = 4,
  parameter int PAGE_BITS = 12
) (
  input  logic       clk_i,
  input  logic       rsn_i,
  dtlb_stage_if.slave tl
);

  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int PTR_W = $clog2(ENTRIES);

  typedef enum logic {RUN, FAULT} state_e;
  typedef logic [VPN_W-1:0] vpn_t;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] ent_vld_q, ent_vld_d;
  vpn_t               ent_vpn_q [ENTRIES];
  vpn_t               ent_vpn_d [ENTRIES];
  vpn_t               ent_ppn_q [ENTRIES];
  vpn_t               ent_ppn_d [ENTRIES];
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               valid_q, valid_d;
  logic               store_q, store_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               miss_q, miss_d;
  logic [31:0]        fva_q, fva_d;

  vpn_t               lk_vpn, wr_vpn, wr_ppn, lk_ppn;
  logic [ENTRIES-1:0] lk_match, wr_match;
  logic               lk_hit, wr_hit;
  logic [PTR_W-1:0]   wr_idx;
  logic               hit_evt, miss_evt;

  assign lk_vpn = tl.tl_cache_addr_i[31:PAGE_BITS];
  assign wr_vpn = tl.tl_read_data_a_i[31:PAGE_BITS];
  assign wr_ppn = tl.tl_read_data_b_i[31:PAGE_BITS];

  // At most one entry can match a VPN, so OR-ing matched PPNs yields the hit PPN.
  always_comb begin
    lk_hit = 1'b0;
    wr_hit = 1'b0;
    lk_ppn = '0;
    wr_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = ent_vld_q[i] && (ent_vpn_q[i] == lk_vpn);
      wr_match[i] = ent_vld_q[i] && (ent_vpn_q[i] == wr_vpn);
      if (lk_match[i]) begin
        lk_hit = 1'b1;
        lk_ppn = lk_ppn | ent_ppn_q[i];
      end
      if (wr_match[i]) begin
        wr_hit = 1'b1;
        wr_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ent_vld_d = ent_vld_q;
    ent_vpn_d = ent_vpn_q;
    ent_ppn_d = ent_ppn_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    store_d   = store_q;
    paddr_d   = paddr_q;
    miss_d    = miss_q;
    fva_d     = fva_q;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;

    if (tl.kill_i) begin
      state_d = RUN;
      valid_d = 1'b0;
      store_d = 1'b0;
      miss_d  = 1'b0;
    end else if (!tl.stall_core_i) begin
      case (state_q)
        RUN: begin
          valid_d = 1'b0;
          store_d = 1'b0;
          // Any tlbwrite (even one aimed at the ITLB) drops a coincident lookup.
          if (tl.tl_tlbwrite_i) begin
            if (tl.tl_idtlb_i) begin
              if (wr_hit) begin
                ent_ppn_d[wr_idx] = wr_ppn;
              end else begin
                ent_vld_d[ptr_q] = 1'b1;
                ent_vpn_d[ptr_q] = wr_vpn;
                ent_ppn_d[ptr_q] = wr_ppn;
                ptr_d            = ptr_q + 1'b1;
              end
            end
          end else if (tl.tl_cache_enable_i) begin
            if (tl.sup_mode_i) begin
              valid_d = 1'b1;
              store_d = tl.tl_store_i;
              paddr_d = tl.tl_cache_addr_i;
            end else if (lk_hit) begin
              valid_d = 1'b1;
              store_d = tl.tl_store_i;
              paddr_d = {lk_ppn, tl.tl_cache_addr_i[PAGE_BITS-1:0]};
              hit_evt = 1'b1;
            end else begin
              miss_d   = 1'b1;
              fva_d    = tl.tl_cache_addr_i;
              state_d  = FAULT;
              miss_evt = 1'b1;
            end
          end
        end
        FAULT: begin
          valid_d = 1'b0;
          store_d = 1'b0;
          miss_d  = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q   <= RUN;
      ent_vld_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      store_q   <= 1'b0;
      paddr_q   <= '0;
      miss_q    <= 1'b0;
      fva_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_vpn_q[i] <= '0;
        ent_ppn_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ent_vld_q <= ent_vld_d;
      ent_vpn_q <= ent_vpn_d;
      ent_ppn_q <= ent_ppn_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      store_q   <= store_d;
      paddr_q   <= paddr_d;
      miss_q    <= miss_d;
      fva_q     <= fva_d;
    end
  end

  assign tl.dtlb_valid_o       = valid_q;
  assign tl.dtlb_store_o       = store_q;
  assign tl.dtlb_paddr_o       = paddr_q;
  assign tl.dtlb_miss_o        = miss_q;
  assign tl.dtlb_fault_vaddr_o = fva_q;

`ifdef DTLB_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (hit_evt && (hits_q != 32'hFFFF_FFFF))
      hits_d = hits_q + 32'd1;
    if (miss_evt && (misses_q != 32'hFFFF_FFFF))
      misses_d = misses_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign tl.dtlb_hits_o   = hits_q;
  assign tl.dtlb_misses_o = misses_q;
`else
  logic unused_stats;
  assign unused_stats     = hit_evt | miss_evt;
  assign tl.dtlb_hits_o   = 32'h0;
  assign tl.dtlb_misses_o = 32'h0;
`endif

  // Page-offset bits of the tlbwrite operands carry no translation information.
  logic unused_offsets;
  assign unused_offsets = ^{tl.tl_read_data_a_i[PAGE_BITS-1:0], tl.tl_read_data_b_i[PAGE_BITS-1:0]};

  a_lookup_unique: assert property (@(posedge clk_i) disable iff (!rsn_i) $onehot0(lk_match));
  a_write_unique:  assert property (@(posedge clk_i) disable iff (!rsn_i) $onehot0(wr_match));
  a_valid_miss:    assert property (@(posedge clk_i) disable iff (!rsn_i) !(valid_q && miss_q));
  a_fault_sticky:  assert property (@(posedge clk_i) disable iff (!rsn_i) (state_q == FAULT) |-> miss_q);

endmodule

// File: tb/tb_dtlb_stage.sv
// Scoreboard bench for dtlb_stage: each driven cycle queues its expected registered outputs, popped one edge later.
module tb_dtlb_stage;

  logic clk = 1'b0;
  logic rsn;
  always #5 clk = ~clk;

  dtlb_stage_if bus ();

  dtlb_stage #(.ENTRIES(4), .PAGE_BITS(12)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .tl    (bus)
  );

`ifdef DTLB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct packed {
    logic        en, st, tw, id, sup, kl, sl;
    logic [31:0] va, a, b;
  } stim_t;

  typedef struct packed {
    logic        vld, st, miss;
    logic [31:0] pa, fva, hits, misses;
  } obs_t;

  obs_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ld(input logic [31:0] va, input logic st);
    stim_t s;
    s = '0; s.en = 1'b1; s.va = va; s.st = st;
    return s;
  endfunction

  function automatic stim_t wr(input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = '0; s.tw = 1'b1; s.id = 1'b1; s.a = a; s.b = b;
    return s;
  endfunction

  // Expected outputs; dh/dm are the hit/miss events this cycle should count.
  function automatic obs_t o(input logic v, input logic s, input logic m,
                             input logic [31:0] pa, input logic [31:0] fva,
                             input int dh, input int dm);
    exp_hits   += dh * STATS;
    exp_misses += dm * STATS;
    return {v, s, m, pa, fva, 32'(exp_hits), 32'(exp_misses)};
  endfunction

  function automatic obs_t sample();
    return {bus.dtlb_valid_o, bus.dtlb_store_o, bus.dtlb_miss_o, bus.dtlb_paddr_o,
            bus.dtlb_fault_vaddr_o, bus.dtlb_hits_o, bus.dtlb_misses_o};
  endfunction

  task automatic drive(input stim_t s);
    bus.kill_i            = s.kl;
    bus.stall_core_i      = s.sl;
    bus.tl_cache_enable_i = s.en;
    bus.tl_store_i        = s.st;
    bus.tl_cache_addr_i   = s.va;
    bus.tl_tlbwrite_i     = s.tw;
    bus.tl_idtlb_i        = s.id;
    bus.tl_read_data_a_i  = s.a;
    bus.tl_read_data_b_i  = s.b;
    bus.sup_mode_i        = s.sup;
  endtask

  task automatic test_reset();
    obs_t got, want;
    rsn = 1'b0;
    drive(idle());
    sb.push_back('0);
    repeat (2) @(posedge clk);
    #1;
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_hold got=%h want=%h", got, want); end
    rsn = 1'b1;
    sb.push_back('0);
    @(posedge clk); #1;
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_idle got=%h want=%h", got, want); end
  endtask

  task automatic test_miss_fault();
    stim_t sq [$]; obs_t eq [$]; stim_t s; obs_t got, want;
    sq.push_back(ld(32'h0000_1234, 1'b0));         eq.push_back(o(0,0,1,32'h0,32'h0000_1234,0,1));
    sq.push_back(ld(32'h0000_5678, 1'b0));         eq.push_back(o(0,0,1,32'h0,32'h0000_1234,0,0));
    sq.push_back(wr(32'h0000_1000, 32'h8000_5000)); eq.push_back(o(0,0,1,32'h0,32'h0000_1234,0,0));
    s = ld(32'h0000_1234, 1'b0); s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'h0,32'h0000_1234,0,0));
    sq.push_back(ld(32'h0000_1234, 1'b0));         eq.push_back(o(0,0,1,32'h0,32'h0000_1234,0,1));
    s = idle(); s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'h0,32'h0000_1234,0,0));
    foreach (sq[i]) begin
      drive(sq[i]); sb.push_back(eq[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL miss_fault[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_write_lookup();
    stim_t sq [$]; obs_t eq [$]; stim_t s; obs_t got, want;
    sq.push_back(wr(32'h0000_1000, 32'h8000_5000)); eq.push_back(o(0,0,0,32'h0,32'h0000_1234,0,0));
    sq.push_back(ld(32'h0000_1234, 1'b0));         eq.push_back(o(1,0,0,32'h8000_5234,32'h0000_1234,1,0));
    sq.push_back(ld(32'h0000_1FFC, 1'b1));         eq.push_back(o(1,1,0,32'h8000_5FFC,32'h0000_1234,1,0));
    sq.push_back(idle());                          eq.push_back(o(0,0,0,32'h8000_5FFC,32'h0000_1234,0,0));
    s = wr(32'h0000_2000, 32'h7000_2000); s.id = 1'b0; s.en = 1'b1; s.va = 32'h0000_1234;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'h8000_5FFC,32'h0000_1234,0,0));
    sq.push_back(ld(32'h0000_2000, 1'b0));         eq.push_back(o(0,0,1,32'h8000_5FFC,32'h0000_2000,0,1));
    s = idle(); s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'h8000_5FFC,32'h0000_2000,0,0));
    foreach (sq[i]) begin
      drive(sq[i]); sb.push_back(eq[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL write_lookup[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_overwrite();
    stim_t sq [$]; obs_t eq [$]; stim_t s; obs_t got, want;
    sq.push_back(wr(32'h0000_2000, 32'h7000_2000)); eq.push_back(o(0,0,0,32'h8000_5FFC,32'h0000_2000,0,0));
    s = wr(32'h0000_1000, 32'h9000_0000); s.en = 1'b1; s.va = 32'h0000_1010;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'h8000_5FFC,32'h0000_2000,0,0));
    sq.push_back(ld(32'h0000_1010, 1'b0));         eq.push_back(o(1,0,0,32'h9000_0010,32'h0000_2000,1,0));
    sq.push_back(ld(32'h0000_2ABC, 1'b1));         eq.push_back(o(1,1,0,32'h7000_2ABC,32'h0000_2000,1,0));
    sq.push_back(wr(32'h0000_3000, 32'h3000_3000)); eq.push_back(o(0,0,0,32'h7000_2ABC,32'h0000_2000,0,0));
    sq.push_back(wr(32'h0000_4000, 32'h4000_4000)); eq.push_back(o(0,0,0,32'h7000_2ABC,32'h0000_2000,0,0));
    sq.push_back(wr(32'h0000_5000, 32'h5000_5000)); eq.push_back(o(0,0,0,32'h7000_2ABC,32'h0000_2000,0,0));
    sq.push_back(ld(32'h0000_2AB0, 1'b0));         eq.push_back(o(1,0,0,32'h7000_2AB0,32'h0000_2000,1,0));
    sq.push_back(ld(32'h0000_5004, 1'b0));         eq.push_back(o(1,0,0,32'h5000_5004,32'h0000_2000,1,0));
    sq.push_back(ld(32'h0000_1010, 1'b0));         eq.push_back(o(0,0,1,32'h5000_5004,32'h0000_1010,0,1));
    s = idle(); s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'h5000_5004,32'h0000_1010,0,0));
    foreach (sq[i]) begin
      drive(sq[i]); sb.push_back(eq[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL overwrite[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_fifo_wrap();
    stim_t sq [$]; obs_t eq [$]; stim_t s; obs_t got, want;
    rsn = 1'b0;
    drive(idle());
    @(posedge clk); #1;
    rsn = 1'b1;
    exp_hits = 0; exp_misses = 0;
    for (int k = 0; k < 5; k++) begin
      sq.push_back(wr(32'h0001_0000 + 32'(k) * 32'h1000, 32'hA001_0000 + 32'(k) * 32'h1000));
      eq.push_back(o(0,0,0,32'h0,32'h0,0,0));
    end
    sq.push_back(ld(32'h0001_1008, 1'b0));         eq.push_back(o(1,0,0,32'hA001_1008,32'h0,1,0));
    sq.push_back(ld(32'h0001_2008, 1'b1));         eq.push_back(o(1,1,0,32'hA001_2008,32'h0,1,0));
    sq.push_back(ld(32'h0001_3008, 1'b0));         eq.push_back(o(1,0,0,32'hA001_3008,32'h0,1,0));
    sq.push_back(ld(32'h0001_4008, 1'b0));         eq.push_back(o(1,0,0,32'hA001_4008,32'h0,1,0));
    sq.push_back(ld(32'h0001_0008, 1'b0));         eq.push_back(o(0,0,1,32'hA001_4008,32'h0001_0008,0,1));
    s = idle(); s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'hA001_4008,32'h0001_0008,0,0));
    sq.push_back(wr(32'h0001_5000, 32'hA001_5000)); eq.push_back(o(0,0,0,32'hA001_4008,32'h0001_0008,0,0));
    sq.push_back(ld(32'h0001_2010, 1'b0));         eq.push_back(o(1,0,0,32'hA001_2010,32'h0001_0008,1,0));
    sq.push_back(ld(32'h0001_1010, 1'b0));         eq.push_back(o(0,0,1,32'hA001_2010,32'h0001_1010,0,1));
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'hA001_2010,32'h0001_1010,0,0));
    foreach (sq[i]) begin
      drive(sq[i]); sb.push_back(eq[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL fifo_wrap[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_stall_kill();
    stim_t sq [$]; obs_t eq [$]; stim_t s; obs_t got, want;
    sq.push_back(ld(32'h0001_2345, 1'b0));         eq.push_back(o(1,0,0,32'hA001_2345,32'h0001_1010,1,0));
    s = ld(32'h0001_3000, 1'b1); s.sl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(1,0,0,32'hA001_2345,32'h0001_1010,0,0));
    sq.push_back(s);                               eq.push_back(o(1,0,0,32'hA001_2345,32'h0001_1010,0,0));
    s = wr(32'h0009_9000, 32'h9900_0000); s.sl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(1,0,0,32'hA001_2345,32'h0001_1010,0,0));
    s = ld(32'h0001_3000, 1'b1); s.sl = 1'b1; s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'hA001_2345,32'h0001_1010,0,0));
    sq.push_back(ld(32'h0001_3000, 1'b1));         eq.push_back(o(1,1,0,32'hA001_3000,32'h0001_1010,1,0));
    sq.push_back(ld(32'h0009_9000, 1'b0));         eq.push_back(o(0,0,1,32'hA001_3000,32'h0009_9000,0,1));
    s = idle(); s.sl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,1,32'hA001_3000,32'h0009_9000,0,0));
    s.kl = 1'b1;
    sq.push_back(s);                               eq.push_back(o(0,0,0,32'hA001_3000,32'h0009_9000,0,0));
    sq.push_back(ld(32'h0001_5ABC, 1'b0));         eq.push_back(o(1,0,0,32'hA001_5ABC,32'h0009_9000,1,0));
    foreach (sq[i]) begin
      drive(sq[i]); sb.push_back(eq[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL stall_kill[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_sup_bypass();
    stim_t sq [$]; obs_t eq [$]; stim_t s; obs_t got, want;
    s = ld(32'hC000_0044, 1'b0); s.sup = 1'b1;
    sq.push_back(s);                               eq.push_back(o(1,0,0,32'hC000_0044,32'h0009_9000,0,0));
    s = ld(32'h7777_7770, 1'b1); s.sup = 1'b1;
    sq.push_back(s);                               eq.push_back(o(1,1,0,32'h7777_7770,32'h0009_9000,0,0));
    sq.push_back(idle());                          eq.push_back(o(0,0,0,32'h7777_7770,32'h0009_9000,0,0));
    sq.push_back(ld(32'h0001_4FFF, 1'b0));         eq.push_back(o(1,0,0,32'hA001_4FFF,32'h0009_9000,1,0));
    foreach (sq[i]) begin
      drive(sq[i]); sb.push_back(eq[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL sup_bypass[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_miss_fault();
    test_write_lookup();
    test_overwrite();
    test_fifo_wrap();
    test_stall_kill();
    test_sup_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
